// File: rtl/fft_sample_loader_if.sv
// Handshake bundle between the sample stream / FFT consumer and fft_sample_loader.
// The loader takes the slave view; the source/consumer side takes the master view.
interface fft_sample_loader_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned LOG2N = 5,
  parameter int unsigned DW    = 8
);
  logic                  s_valid;
  logic [DW-1:0]         s_data;
  logic                  s_last;
  logic                  s_ready;
  logic                  frame_valid;
  logic [N*2*DW-1:0]     frame_data;
  logic                  frame_ack;
  logic                  frame_err;
  logic [LOG2N-1:0]      wr_count;

  modport master (
    output s_valid, s_data, s_last, frame_ack,
    input  s_ready, frame_valid, frame_data, frame_err, wr_count
  );

  modport slave (
    input  s_valid, s_data, s_last, frame_ack,
    output s_ready, frame_valid, frame_data, frame_err, wr_count
  );
endinterface

// File: rtl/fft_sample_loader.sv
// Ping-pong input frame buffer for the 32-point FFT: stores serial real samples at
// bit-reversed slots as {real, 0} and holds each completed frame until acknowledged.
module fft_sample_loader #(
  parameter int unsigned N     = 32,
  parameter int unsigned LOG2N = 5,
  parameter int unsigned DW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  fft_sample_loader_if.slave  bus
);

  localparam int unsigned WW = 2 * DW;

  logic [WW-1:0]    bank_q [2][N];
  logic [1:0]       full_q;
  logic [1:0]       full_d;
  logic             wr_bank_q;
  logic             rd_bank_q;
  logic [LOG2N-1:0] wr_cnt_q;
  logic             err_q;

  logic             ready_c;
  logic             accept_c;
  logic             last_slot_c;
  logic             frame_done_c;
  logic             ack_c;
  logic [LOG2N-1:0] wr_slot_c;

  assign ready_c      = ~full_q[wr_bank_q];
  assign accept_c     = bus.s_valid & ready_c;
  assign last_slot_c  = (wr_cnt_q == LOG2N'(N - 1));
  assign frame_done_c = accept_c & last_slot_c;
  assign ack_c        = bus.frame_ack & full_q[rd_bank_q];
  assign wr_slot_c    = {<<{wr_cnt_q}};

  // Completion and ack always target different banks, so both can apply together.
  always_comb begin
    full_d = full_q;
    if (ack_c)        full_d[rd_bank_q] = 1'b0;
    if (frame_done_c) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q    <= '{default: '0};
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      full_q <= full_d;
      // A framing error is s_last disagreeing with the slot position.
      err_q  <= accept_c & (bus.s_last != last_slot_c);
      if (accept_c) begin
        bank_q[wr_bank_q][wr_slot_c] <= {bus.s_data, DW'(0)};
        wr_cnt_q <= (last_slot_c || bus.s_last) ? '0 : wr_cnt_q + 1'b1;
      end
      if (frame_done_c) wr_bank_q <= ~wr_bank_q;
      if (ack_c)        rd_bank_q <= ~rd_bank_q;
    end
  end

  assign bus.s_ready     = ready_c;
  assign bus.frame_valid = full_q[rd_bank_q];
  assign bus.frame_err   = err_q;
  assign bus.wr_count    = wr_cnt_q;

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign bus.frame_data[k*WW +: WW] = bank_q[rd_bank_q][k];
  end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader: constant vector table, directed
// corner sequences, and a randomized run against a frame-queue reference model.
module tb_fft_sample_loader;

  localparam int unsigned N     = 32;
  localparam int unsigned LOG2N = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned WW    = 2 * DW;
  localparam int unsigned FW    = N * WW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_sample_loader_if #(.N(N), .LOG2N(LOG2N), .DW(DW)) bus ();

  fft_sample_loader #(.N(N), .LOG2N(LOG2N), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: completed frames awaiting ack, plus the samples of the filling frame.
  typedef struct { logic [DW-1:0] s [N]; } frame_t;
  frame_t        pend [$];
  logic [DW-1:0] cur  [$];
  logic          exp_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          l;
    logic          a;
    logic          rdy;
    logic [LOG2N-1:0] cnt;
    logic          err;
  } vec_t;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev(input int k);
    int r = 0;
    int x = k;
    for (int i = 0; i < int'(LOG2N); i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] exp_vec(input frame_t f);
    logic [FW-1:0] r = '0;
    for (int k = 0; k < int'(N); k++) r[k*WW +: WW] = {f.s[rev(k)], DW'(0)};
    return r;
  endfunction

  function automatic logic [WW-1:0] slot(input int k);
    return bus.frame_data[k*WW +: WW];
  endfunction

  task automatic check_frame(input string name, input frame_t f);
    logic [FW-1:0] e = exp_vec(f);
    int bad = -1;
    n_checks++;
    if (bus.frame_data !== e) begin
      n_fail++;
      for (int k = 0; k < int'(N); k++)
        if (bad < 0 && bus.frame_data[k*WW +: WW] !== e[k*WW +: WW]) bad = k;
      $display("FAIL %s: slot %0d got %h expected %h at %0t", name, bad,
               bus.frame_data[bad*WW +: WW], e[bad*WW +: WW], $time);
    end
  endtask

  task automatic model_check();
    check("frame_valid", 32'(bus.frame_valid), 32'(pend.size() > 0));
    check("s_ready", 32'(bus.s_ready), 32'(pend.size() < 2));
    check("wr_count", 32'(bus.wr_count), 32'(cur.size()));
    check("frame_err", 32'(bus.frame_err), 32'(exp_err));
    if (pend.size() > 0) check_frame("frame_data", pend[0]);
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic l, input logic a);
    bit acc = v && (pend.size() < 2);
    bit ak  = a && (pend.size() > 0);
    exp_err = 1'b0;
    if (ak) void'(pend.pop_front());
    if (acc) begin
      cur.push_back(d);
      if (cur.size() == int'(N)) begin
        frame_t f;
        for (int k = 0; k < int'(N); k++) f.s[k] = cur[k];
        pend.push_back(f);
        exp_err = ~l;
        cur.delete();
      end else if (l) begin
        exp_err = 1'b1;
        cur.delete();
      end
    end
  endtask

  // Called at a negedge: drive, take the rising edge, then compare at the next negedge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l, input logic a);
    bus.s_valid   = v;
    bus.s_data    = d;
    bus.s_last    = l;
    bus.frame_ack = a;
    @(posedge clk);
    model_step(v, d, l, a);
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_last    = 1'b0;
    bus.frame_ack = 1'b0;
    @(posedge clk);
    pend.delete();
    cur.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("reset frame_data zero", 32'(bus.frame_data === '0), 32'd1);
    model_check();
  endtask

  task automatic send(input int base, input int cnt, input int last_idx, input int ack_idx);
    for (int n = 0; n < cnt; n++)
      cycle(1'b1, DW'(base + n), n == last_idx, n == ack_idx);
  endtask

  vec_t tbl [7];
  logic rv, rl, ra;
  logic [DW-1:0] rd;

  initial begin
    exp_err = 1'b0;
    do_reset();

    // Short framing-error and ignored-ack vectors from reset.
    tbl[0] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0};
    tbl[2] = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0};
    tbl[3] = '{1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0};
    tbl[5] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1};
    tbl[6] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].a);
      check($sformatf("tbl%0d s_ready", i), 32'(bus.s_ready), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d wr_count", i), 32'(bus.wr_count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d frame_err", i), 32'(bus.frame_err), 32'(tbl[i].err));
      check($sformatf("tbl%0d frame_valid", i), 32'(bus.frame_valid), 32'd0);
    end

    // Single frame 0..31, bit-reversed placement.
    do_reset();
    send(0, 31, -1, -1);
    check("valid before last", 32'(bus.frame_valid), 32'd0);
    send(31, 1, 0, -1);
    check("valid after last", 32'(bus.frame_valid), 32'd1);
    check("slot0", 32'(slot(0)), 32'h0000);
    check("slot1", 32'(slot(1)), 32'h1000);
    check("slot2", 32'(slot(2)), 32'h0800);
    check("slot16", 32'(slot(16)), 32'h0100);
    check("slot31", 32'(slot(31)), 32'h1F00);

    // Second frame fills the other bank; then stall until the ack.
    send(32, 32, 31, -1);
    check("s_ready both full", 32'(bus.s_ready), 32'd0);
    check("still frame A slot1", 32'(slot(1)), 32'h1000);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'd64, 1'b0, 1'b0);
    check("stall wr_count", 32'(bus.wr_count), 32'd0);
    cycle(1'b1, 8'd64, 1'b0, 1'b1);
    check("frame B slot1", 32'(slot(1)), 32'h3000);
    check("s_ready after ack", 32'(bus.s_ready), 32'd1);
    cycle(1'b1, 8'd64, 1'b0, 1'b0);
    check("stalled sample taken", 32'(bus.wr_count), 32'd1);

    // Ack of B lands on the last sample of C: valid stays up, data switches.
    send(65, 30, -1, -1);
    cycle(1'b1, 8'd95, 1'b1, 1'b1);
    check("switch valid", 32'(bus.frame_valid), 32'd1);
    check("switch slot0", 32'(slot(0)), 32'h4000);
    check("switch slot1", 32'(slot(1)), 32'h5000);

    // s_last on sample 9, then a clean frame.
    do_reset();
    send(0, 10, 9, -1);
    check("early last err", 32'(bus.frame_err), 32'd1);
    check("early last count", 32'(bus.wr_count), 32'd0);
    check("early last no valid", 32'(bus.frame_valid), 32'd0);
    cycle(1'b0, 8'd0, 1'b0, 1'b0);
    check("err single pulse", 32'(bus.frame_err), 32'd0);
    send(100, 32, 31, -1);
    check("recovered valid", 32'(bus.frame_valid), 32'd1);
    check("recovered slot1", 32'(slot(1)), 32'h7400);

    // Missing s_last: frame still completes with an error pulse.
    send(200, 32, -1, -1);
    check("missing last err", 32'(bus.frame_err), 32'd1);
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    check("missing last frame slot1", 32'(slot(1)), 32'hD800);
    check("missing last err cleared", 32'(bus.frame_err), 32'd0);

    // Reset with a frame pending and 20 samples in flight.
    send(10, 20, -1, -1);
    do_reset();
    check("rst valid", 32'(bus.frame_valid), 32'd0);
    check("rst wr_count", 32'(bus.wr_count), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom % 5) != 0;
      rd = DW'($urandom);
      rl = (cur.size() == int'(N) - 1) ? (($urandom % 8) != 0) : (($urandom % 40) == 0);
      ra = ($urandom % 3) == 0;
      cycle(rv, rd, rl, ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
